// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60 timing defaults, derived line/frame constants and helpers
// used by the sync generator and the downstream renderer.
package vga_sync_pkg;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned CLK_DIV_DEF   = 4;

    localparam int unsigned H_TOTAL_DEF  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    localparam int unsigned COORD_W = 10;

    // Registered sync pair; both lines are active low.
    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_pair_t;

    // Counter width able to hold 0..modulus-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable; wrap flags the terminal count MOD-1.
module mod_counter #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned MOD   = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign wrap = (cnt_q == WIDTH'(MOD - 1));
    assign q    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, raw h/v counters, zero-skew
// registered syncs and a frame-start pulse on the (0,0) wrap.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam int unsigned DIV_W    = cnt_width(CLK_DIV);

    logic [DIV_W-1:0]   div_cnt;
    logic               div_wrap;
    logic [COORD_W-1:0] h_cnt;
    logic               h_wrap;
    logic [COORD_W-1:0] v_cnt;
    logic               v_wrap;
    logic               v_en;

    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    sync_pair_t         sync_q;
    sync_pair_t         sync_d;
    logic               frame_start_q;
    logic               frame_start_d;

    mod_counter #(.WIDTH(DIV_W), .MOD(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (div_cnt),
        .wrap  (div_wrap)
    );

    mod_counter #(.WIDTH(COORD_W), .MOD(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (div_wrap),
        .q     (h_cnt),
        .wrap  (h_wrap)
    );

    assign v_en = div_wrap & h_wrap;

    mod_counter #(.WIDTH(COORD_W), .MOD(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .q     (v_cnt),
        .wrap  (v_wrap)
    );

    assign p_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign x        = h_cnt;
    assign y        = v_cnt;
    assign video_on = (h_cnt < COORD_W'(H_DISPLAY)) && (v_cnt < COORD_W'(V_DISPLAY));

    // Syncs decode the counts the counters are about to load, so they land with x/y.
    always_comb begin
        h_next        = h_cnt;
        v_next        = v_cnt;
        sync_d        = sync_q;
        frame_start_d = 1'b0;
        if (div_wrap) begin
            h_next = h_wrap ? '0 : h_cnt + COORD_W'(1);
        end
        if (v_en) begin
            v_next = v_wrap ? '0 : v_cnt + COORD_W'(1);
        end
        sync_d.hsync  = !((h_next >= COORD_W'(HS_START)) && (h_next <= COORD_W'(HS_END)));
        sync_d.vsync  = !((v_next >= COORD_W'(VS_START)) && (v_next <= COORD_W'(VS_END)));
        frame_start_d = v_en & v_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '{hsync: 1'b1, vsync: 1'b1};
            frame_start_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = sync_q.hsync;
    assign vsync       = sync_q.vsync;
    assign frame_start = frame_start_q;

endmodule
